op_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the matrix `controller`. It accepts 32-bit operation words from the host through a small command FIFO and drives the controller's `enable`/`operation`/`in_data` for exactly the number of cycles each opcode needs. For serial loads (opcode 2) it streams host write data into the controller; for serial dumps (opcode 3) it returns `out_data` to the host through a valid/ready port. It also inserts the idle cycle the controller needs between consecutive multiplies to see a fresh rising edge of `opcode == 1`.

---
 rtl/seq_pkg.sv | 28 ++
 rtl/cmd_fifo.sv | 60 ++++++
 rtl/op_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_op_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared opcode values, sequencer state encoding and operation-word
// field helpers for the op_sequencer slice.
package seq_pkg;

  localparam logic [3:0] OP_IDLE = 4'd0;
  localparam logic [3:0] OP_MULT = 4'd1;
  localparam logic [3:0] OP_LOAD = 4'd2;
  localparam logic [3:0] OP_DUMP = 4'd3;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    LOAD,
    DUMP,
    GAP
  } seq_state_t;

  // Opcode field of an operation word.
  function automatic logic [3:0] op_code(input logic [31:0] op);
    return op[3:0];
  endfunction

  // True for the opcodes the sequencer actually executes.
  function automatic logic op_known(input logic [31:0] op);
    return (op[3:0] == OP_MULT) || (op[3:0] == OP_LOAD) || (op[3:0] == OP_DUMP);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous command FIFO with registered storage.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset (pointers/count only)
//   push, wdata     - write request and data; accepted when not full, or when
//                     full and popping in the same cycle
//   pop, rdata      - read request and head-of-queue data (show-ahead)
//   full, empty     - occupancy flags
//   count           - number of stored entries
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/op_sequencer.sv
// op_sequencer: command sequencer in front of the matrix controller.
// Pops operation words from a small FIFO and drives the controller's
// enable/operation/in_data for as long as each opcode needs.
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_data   - host command push
//   wr_valid/wr_ready/wr_data      - host load data (opcode 2)
//   rd_valid/rd_ready/rd_data      - dump data to host (opcode 3)
//   ctl_enable/ctl_operation/ctl_in_data - controller drive
//   ctl_out_data                   - controller read data, one cycle after issue
//   busy, done, illegal_op         - status
module op_sequencer
  import seq_pkg::*;
#(
  parameter int CMD_DEPTH   = 4,
  parameter int PAGE_WORDS  = 64,
  parameter int MULT_CYCLES = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        ctl_enable,
  output logic [31:0] ctl_operation,
  output logic [31:0] ctl_in_data,
  input  logic [31:0] ctl_out_data,
  output logic        busy,
  output logic        done,
  output logic        illegal_op
);

  localparam int MW = $clog2(MULT_CYCLES);
  localparam int PW = $clog2(PAGE_WORDS) + 1;
  localparam int CW = $clog2(CMD_DEPTH) + 1;

  seq_state_t     state, state_nxt;
  logic [31:0]    op_reg;
  logic [MW-1:0]  mcnt;
  logic [PW-1:0]  wcnt;       // load handshakes / dump words delivered
  logic [PW-1:0]  issued;     // dump reads issued
  logic           inflight;   // read issued last cycle, data arrives now
  logic [1:0]     buf_count;
  logic [31:0]    buf0, buf1;

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]    fifo_rdata;
  logic [CW-1:0]  fifo_count;
  logic           en_raw, rd_issue, rd_pop;

  // The pop slot is offered to the host so a full FIFO can still take a push.
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full || fifo_pop;
  assign fifo_push = cmd_valid && cmd_ready;

  cmd_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (cmd_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rd_valid   = (buf_count != 2'd0);
  assign rd_data    = rd_valid ? buf0 : 32'd0;
  assign rd_pop     = rd_valid && rd_ready;
  assign busy       = (fifo_count != '0) || (state != IDLE);
  // IDLE drives enable high; masking with reset keeps it low while reset is held.
  assign ctl_enable = en_raw && !reset;

  always_comb begin
    state_nxt     = state;
    en_raw        = 1'b0;
    ctl_operation = 32'd0;
    ctl_in_data   = 32'd0;
    wr_ready      = 1'b0;
    done          = 1'b0;
    rd_issue      = 1'b0;
    case (state)
      IDLE: begin
        en_raw = 1'b1;
        if (!fifo_empty) begin
          case (op_code(fifo_rdata))
            OP_MULT: state_nxt = MULT;
            OP_LOAD: state_nxt = LOAD;
            OP_DUMP: state_nxt = DUMP;
            // Discarded opcodes retire through GAP so done never meets a pop.
            default: state_nxt = GAP;
          endcase
        end
      end
      MULT: begin
        ctl_operation = op_reg;
        en_raw        = 1'b1;
        if (mcnt == MW'(MULT_CYCLES - 1)) state_nxt = GAP;
      end
      LOAD: begin
        ctl_operation = op_reg;
        wr_ready      = 1'b1;
        en_raw        = wr_valid;
        ctl_in_data   = wr_data;
        if (wr_valid && (wcnt == PW'(PAGE_WORDS - 1))) state_nxt = GAP;
      end
      DUMP: begin
        ctl_operation = op_reg;
        // Never issue more reads than the skid buffer can absorb.
        rd_issue = (issued < PW'(PAGE_WORDS)) &&
                   ((buf_count + {1'b0, inflight}) < 2'd2);
        en_raw   = rd_issue;
        if (rd_pop && (wcnt == PW'(PAGE_WORDS - 1))) state_nxt = GAP;
      end
      GAP: begin
        en_raw    = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mcnt       <= '0;
      wcnt       <= '0;
      issued     <= '0;
      inflight   <= 1'b0;
      buf_count  <= 2'd0;
      illegal_op <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        mcnt     <= '0;
        wcnt     <= '0;
        issued   <= '0;
        inflight <= 1'b0;
        if (fifo_pop && !op_known(fifo_rdata) && (op_code(fifo_rdata) != OP_IDLE))
          illegal_op <= 1'b1;
      end
      if (state == MULT) mcnt <= mcnt + MW'(1);
      if ((state == LOAD) && wr_valid) wcnt <= wcnt + PW'(1);
      if (state == DUMP) begin
        issued   <= issued + PW'(rd_issue);
        inflight <= rd_issue;
        if (rd_pop) wcnt <= wcnt + PW'(1);
      end
      case ({inflight, rd_pop})
        2'b10:   buf_count <= buf_count + 2'd1;
        2'b01:   buf_count <= buf_count - 2'd1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  // Data registers: command latch and the two-entry dump skid buffer.
  always_ff @(posedge clk) begin
    if (fifo_pop) op_reg <= fifo_rdata;
    if (inflight) begin
      if (rd_pop) begin
        if (buf_count == 2'd2) begin
          buf0 <= buf1;
          buf1 <= ctl_out_data;
        end else begin
          buf0 <= ctl_out_data;
        end
      end else if (buf_count == 2'd0) begin
        buf0 <= ctl_out_data;
      end else begin
        buf1 <= ctl_out_data;
      end
    end else if (rd_pop) begin
      buf0 <= buf1;
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: scoreboard bench for op_sequencer with a behavioural
// controller model, directed scenarios and a randomized command phase.
module tb_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = 32'd0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        ctl_enable;
  logic [31:0] ctl_operation;
  logic [31:0] ctl_in_data;
  logic [31:0] ctl_out_data = 32'd0;
  logic        busy;
  logic        done;
  logic        illegal_op;

  op_sequencer #(.CMD_DEPTH(4), .PAGE_WORDS(64), .MULT_CYCLES(80)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_data      (cmd_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .ctl_enable    (ctl_enable),
    .ctl_operation (ctl_operation),
    .ctl_in_data   (ctl_in_data),
    .ctl_out_data  (ctl_out_data),
    .busy          (busy),
    .done          (done),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hash(input int k);
    logic [31:0] kk;
    kk = k;
    return (kk * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // ---------------- reference model / scoreboard queues ----------------
  logic [31:0] op_q[$];
  logic [31:0] load_q[$];
  logic [31:0] rd_q[$];
  int          exp_done = 0;
  logic        exp_illegal = 1'b0;
  logic [31:0] next_wr = 32'd0;
  int          next_rd = 0;
  bit          mon_en = 1'b0;

  task automatic model_push(input logic [31:0] w);
    exp_done++;
    case (w[3:0])
      4'd0: ;
      4'd1: op_q.push_back(w);
      4'd2: begin
        op_q.push_back(w);
        for (int i = 0; i < 64; i++) begin
          load_q.push_back(next_wr);
          next_wr++;
        end
      end
      4'd3: begin
        op_q.push_back(w);
        for (int i = 0; i < 64; i++) begin
          rd_q.push_back(hash(next_rd));
          next_rd++;
        end
      end
      default: exp_illegal = 1'b1;
    endcase
  endtask

  // ---------------- host data drivers ----------------
  int          mode = 0;
  int          cyc = 0;
  logic [31:0] wr_idx = 32'd0;
  bit          wr_hs = 1'b0;

  always @(negedge clk) wr_hs = wr_valid && wr_ready;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (wr_hs) wr_idx++;
    wr_data = wr_idx;
    if (mode == 0) begin
      wr_valid = (cyc % 4) != 3;
      rd_ready = (cyc % 2) == 0;
    end else begin
      wr_valid = $urandom_range(0, 3) != 0;
      rd_ready = $urandom_range(0, 2) != 0;
    end
  end

  // ---------------- controller read model ----------------
  int rd_issue_cnt = 0;
  always @(posedge clk) begin
    if (ctl_enable && (ctl_operation[3:0] == 4'd3)) begin
      ctl_out_data <= hash(rd_issue_cnt);
      rd_issue_cnt <= rd_issue_cnt + 1;
    end
  end

  // ---------------- monitor ----------------
  int          done_cnt = 0;
  int          issued_tb = 0;
  int          delivered_tb = 0;
  int          max_out = 0;
  bit          in_run = 1'b0;
  logic [31:0] cur_op = 32'd0;
  int          en_cnt = 0;
  int          zero_run = 100;
  int          exp_len;

  always @(negedge clk) begin
    if (mon_en) begin
      if (done) done_cnt++;

      if (ctl_enable && (ctl_operation[3:0] == 4'd2)) begin
        if (load_q.size() == 0) chk("load_extra_word", ctl_in_data, 32'hxxxxxxxx);
        else chk("ctl_in_data", ctl_in_data, load_q.pop_front());
      end

      if (ctl_enable && (ctl_operation[3:0] == 4'd3)) issued_tb++;
      if (issued_tb - delivered_tb > max_out) max_out = issued_tb - delivered_tb;
      if (rd_valid && rd_ready) begin
        delivered_tb++;
        if (rd_q.size() == 0) chk("rd_extra_word", rd_data, 32'hxxxxxxxx);
        else chk("rd_data", rd_data, rd_q.pop_front());
      end

      if (ctl_operation != 32'd0) begin
        if (!in_run) begin
          in_run = 1'b1;
          chk("gap_before_run_ge2", zero_run >= 2, 1);
          if (op_q.size() == 0) begin
            chk("unexpected_run", ctl_operation, 32'd0);
            cur_op = ctl_operation;
          end else begin
            cur_op = op_q.pop_front();
            chk("run_operation", ctl_operation, cur_op);
          end
          en_cnt = 0;
        end else if (ctl_operation != cur_op) begin
          chk("operation_stable", ctl_operation, cur_op);
        end
        if (ctl_enable) en_cnt++;
      end else begin
        if (in_run) begin
          in_run = 1'b0;
          exp_len = (cur_op[3:0] == 4'd1) ? 80 : 64;
          chk("run_enabled_cycles", en_cnt, exp_len);
          chk("done_after_run", done, 1'b1);
          zero_run = 0;
        end
        zero_run++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [31:0] w);
    int n;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_data  = w;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("cmd_ready_timeout", cmd_ready, 1'b1);
    @(posedge clk);
    if (mon_en) model_push(w);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8000) chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    @(negedge clk);
    while ((ctl_operation == 32'd0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("run_start_timeout", ctl_operation != 32'd0, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] w;
    int r;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 32'd0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_ctl_enable", ctl_enable, 1'b0);
    chk("rst_ctl_operation", ctl_operation, 32'd0);
    chk("rst_ctl_in_data", ctl_in_data, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_illegal_op", illegal_op, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a multiply.
    push(32'h00D21201);
    wait_run();
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_ctl_enable", ctl_enable, 1'b0);
    chk("midrst_ctl_operation", ctl_operation, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_busy", busy, 1'b0);
    chk("postrst_cmd_ready", cmd_ready, 1'b1);
    mon_en = 1'b1;

    // Load with wr_valid dropped every 4th cycle.
    mode = 0;
    push(32'h00000012);
    wait_idle();

    // Dump with rd_ready toggling; first rd_valid two cycles after entry.
    push(32'h00000013);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("dump_rd_valid_early", rd_valid, 1'b0);
    @(negedge clk);
    chk("dump_rd_valid_first", rd_valid, 1'b1);
    wait_idle();

    // Back-to-back multiplies.
    push(32'h00D21201);
    push(32'h00D21201);
    wait_idle();

    // Illegal opcode then a load.
    push(32'h00000007);
    @(negedge clk);
    chk("illegal_done_early", done, 1'b0);
    @(negedge clk);
    chk("illegal_done_pulse", done, 1'b1);
    chk("illegal_op_set", illegal_op, 1'b1);
    push(32'h00000012);
    wait_idle();

    // Fill the FIFO during a multiply, then push on the pop cycle.
    push(32'h00D21201);
    wait_run();
    push(32'h00000013);
    push(32'h00000022);
    push(32'h00D21201);
    push(32'h00000000);
    @(negedge clk);
    chk("fifo_full_cmd_ready", cmd_ready, 1'b0);
    push(32'h00000023);
    @(negedge clk);
    chk("push_pop_keeps_full", cmd_ready, 1'b0);
    wait_idle();

    // Randomized command mix with random host handshakes.
    mode = 1;
    for (int i = 0; i < 16; i++) begin
      w = $urandom();
      r = $urandom_range(0, 9);
      if (r < 2)      w[3:0] = 4'd1;
      else if (r < 5) w[3:0] = 4'd2;
      else if (r < 8) w[3:0] = 4'd3;
      else if (r < 9) w[3:0] = 4'd0;
      else            w[3:0] = 4'($urandom_range(4, 15));
      push(w);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    chk("done_count", done_cnt, exp_done);
    chk("illegal_op_final", illegal_op, exp_illegal);
    chk("op_q_drained", op_q.size(), 0);
    chk("load_q_drained", load_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("outstanding_le2", max_out <= 2, 1'b1);
    chk("final_busy", busy, 1'b0);
    chk("final_rd_valid", rd_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
